// File: rtl/key_sweep_pkg.sv
// Shared definitions for the key sweep engine.
//   state_e  : sweep FSM states, 2-bit encoding
//   SETTLE_W : width of the per-pair hold counter (SETTLE range 0..15)
//   is_max() : terminal-value detection for the key and pattern counters
package key_sweep_pkg;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when the low 'width' bits of 'value' are all ones. Counters stop
  // on this value instead of wrapping, so the sweep is always finite.
  function automatic logic is_max(input logic [63:0] value, input int unsigned width);
    logic result;
    result = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ((i < width) && !value[i]) result = 1'b0;
    end
    return result;
  endfunction

endpackage

// File: rtl/key_sweep_driver_counter.sv
// sweep_counter: saturating up-counter used for the key and pattern indices.
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   clr_i    in  clear to zero (wins over inc_i)
//   inc_i    in  increment; ignored once the count is all ones
//   count_o  out current count (registered)
//   is_max_o out count is all ones
module sweep_counter
  import key_sweep_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         is_max_o
);

  logic [W-1:0] count_q, count_d;

  assign is_max_o = is_max(64'(count_q), W);
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !is_max_o) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/key_sweep_driver.sv
// key_sweep_driver: exhaustive key/pattern sweep for a locked-vs-original
// equivalence miter. Reports the first key for which every input pattern
// produces matching outputs.
//   C          in   clock, rising edge
//   R          in   asynchronous active-low reset
//   start      in   begin a sweep (honoured in IDLE and DONE)
//   abort      in   synchronous abort to IDLE, clears the result
//   eq_in      in   miter per-output equality, 1 = outputs agree
//   key_out    out  key applied to the locked circuit
//   pat_out    out  input pattern applied to both circuits
//   busy       out  sweep in progress
//   done       out  sweep finished, held until the next accepted start
//   found      out  with done: a fully-matching key exists
//   key_found  out  with done&found: first matching key
//   fail_mask  out  OR of ~eq_in over all samples of the current key
module key_sweep_driver
  import key_sweep_pkg::*;
#(
  parameter int KEY_W  = 2,
  parameter int IN_W   = 5,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] eq_in,
  output logic [KEY_W-1:0] key_out,
  output logic [IN_W-1:0]  pat_out,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [KEY_W-1:0] key_found,
  output logic [OUT_W-1:0] fail_mask
);

  localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                found_q, found_d;
  logic [KEY_W-1:0]    key_found_q, key_found_d;
  logic [OUT_W-1:0]    fail_mask_q, fail_mask_d;

  logic key_inc, key_clr, key_max;
  logic pat_inc, pat_clr, pat_max;
  logic pass;

  sweep_counter #(.W(KEY_W)) u_key_cnt (
    .clk      (C),
    .rst_n    (R),
    .clr_i    (key_clr),
    .inc_i    (key_inc),
    .count_o  (key_out),
    .is_max_o (key_max)
  );

  sweep_counter #(.W(IN_W)) u_pat_cnt (
    .clk      (C),
    .rst_n    (R),
    .clr_i    (pat_clr),
    .inc_i    (pat_inc),
    .count_o  (pat_out),
    .is_max_o (pat_max)
  );

  assign pass = &eq_in;

  // NOTE: every signal assigned below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    found_d     = found_q;
    key_found_d = key_found_q;
    fail_mask_d = fail_mask_q;
    key_inc     = 1'b0;
    key_clr     = 1'b0;
    pat_inc     = 1'b0;
    pat_clr     = 1'b0;

    if (abort) begin
      // Abort overrides everything, including a simultaneous start.
      state_d     = ST_IDLE;
      hold_d      = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      found_d     = 1'b0;
      key_found_d = '0;
      fail_mask_d = '0;
      key_clr     = 1'b1;
      pat_clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d     = ST_APPLY;
            hold_d      = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            found_d     = 1'b0;
            key_found_d = '0;
            fail_mask_d = '0;
            key_clr     = 1'b1;
            pat_clr     = 1'b1;
          end
        end
        ST_APPLY: begin
          // The pair is held SETTLE+1 cycles; the CHECK cycle that follows
          // is the only one whose closing edge samples eq_in.
          if (hold_q == SETTLE_L) begin
            state_d = ST_CHECK;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + SETTLE_W'(1);
          end
        end
        ST_CHECK: begin
          fail_mask_d = fail_mask_q | ~eq_in;
          if (pass) begin
            if (!pat_max) begin
              pat_inc = 1'b1;
              state_d = ST_APPLY;
            end else begin
              key_found_d = key_out;
              found_d     = 1'b1;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = ST_DONE;
            end
          end else begin
            if (!key_max) begin
              // First mismatch disqualifies this key; move on immediately.
              key_inc     = 1'b1;
              pat_clr     = 1'b1;
              fail_mask_d = '0;
              state_d     = ST_APPLY;
            end else begin
              found_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      key_found_q <= '0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      key_found_q <= key_found_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign key_found = key_found_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_key_sweep_driver.sv
// Directed bench for key_sweep_driver. A behavioural miter (correct key 2'b01,
// wrong keys corrupt output bit 0 whenever pat[1:0]==2'b11) drives the default
// instance; a second instance with SETTLE=3 sees eq_in glitch early in each
// hold window.
module tb_key_sweep_driver;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       start = 1'b0, abort = 1'b0, start2 = 1'b0;
  logic [1:0] eq_in, eq2;
  logic [1:0] key_out, key_found, fail_mask;
  logic [4:0] pat_out;
  logic       busy, done, found;
  logic [1:0] key_out2, key_found2, fail_mask2;
  logic [4:0] pat_out2;
  logic       busy2, done2, found2;

  int n_tests = 0;
  int n_fail  = 0;
  int eq_mode = 0;  // 0 = miter, 1 = forced 2'b11, 2 = forced 2'b01
  int cyc;

  always #5 C = ~C;

  // Behavioural miter: original and locked circuits, compared per output.
  logic [1:0] orig_y, lock_y, miter_eq;
  logic       corrupt;
  assign orig_y   = {pat_out[4] ^ pat_out[2], (pat_out[0] & pat_out[1]) | pat_out[3]};
  assign corrupt  = (key_out != 2'b01) && (pat_out[1:0] == 2'b11);
  assign lock_y   = orig_y ^ {1'b0, corrupt};
  assign miter_eq = ~(orig_y ^ lock_y);
  assign eq_in    = (eq_mode == 1) ? 2'b11 : (eq_mode == 2) ? 2'b01 : miter_eq;

  key_sweep_driver dut (
    .C(C), .R(R), .start(start), .abort(abort), .eq_in(eq_in),
    .key_out(key_out), .pat_out(pat_out), .busy(busy), .done(done),
    .found(found), .key_found(key_found), .fail_mask(fail_mask)
  );

  key_sweep_driver #(.SETTLE(3)) dut2 (
    .C(C), .R(R), .start(start2), .abort(1'b0), .eq_in(eq2),
    .key_out(key_out2), .pat_out(pat_out2), .busy(busy2), .done(done2),
    .found(found2), .key_found(key_found2), .fail_mask(fail_mask2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise start across one rising edge; returns 1 time unit after that edge.
  task automatic pulse_start();
    @(negedge C);
    start = 1'b1;
    @(posedge C);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done rises (bounded).
  task automatic wait_done(input int max_cyc, output int cycles);
    cycles = 0;
    while (!done && cycles < max_cyc) begin
      @(posedge C);
      #1;
      cycles++;
    end
  endtask

  initial begin
    eq2 = 2'b11;
    repeat (3) @(posedge C);
    #1;
    check("rst_key_out",   32'(key_out),   0);
    check("rst_pat_out",   32'(pat_out),   0);
    check("rst_busy",      32'(busy),      0);
    check("rst_done",      32'(done),      0);
    check("rst_found",     32'(found),     0);
    check("rst_key_found", 32'(key_found), 0);
    check("rst_fail_mask", 32'(fail_mask), 0);
    @(negedge C);
    R = 1'b1;

    // 1: key 00 fails at pattern 3 -> 4*2 cycles, then key 01 passes all 32 -> 64.
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 1);
    check("t1_key0", 32'(key_out), 0);
    wait_done(200, cyc);
    check("t1_cycles",    32'(cyc),       72);
    check("t1_done",      32'(done),      1);
    check("t1_busy",      32'(busy),      0);
    check("t1_found",     32'(found),     1);
    check("t1_key_found", 32'(key_found), 2'b01);
    check("t1_fail_mask", 32'(fail_mask), 0);
    check("t1_key_hold",  32'(key_out),   2'b01);
    check("t1_pat_hold",  32'(pat_out),   31);

    // 2: everything matches -> key 0 found after 32*2 cycles; start from DONE.
    eq_mode = 1;
    pulse_start();
    check("t2_done_cleared", 32'(done), 0);
    check("t2_busy", 32'(busy), 1);
    wait_done(200, cyc);
    check("t2_cycles",    32'(cyc),       64);
    check("t2_found",     32'(found),     1);
    check("t2_key_found", 32'(key_found), 0);

    // 3: output 1 always mismatches -> each key fails at pattern 0.
    eq_mode = 2;
    pulse_start();
    wait_done(200, cyc);
    check("t3_cycles",    32'(cyc),       8);
    check("t3_done",      32'(done),      1);
    check("t3_found",     32'(found),     0);
    check("t3_fail_mask", 32'(fail_mask), 2'b10);
    check("t3_key_last",  32'(key_out),   2'b11);

    // 4: abort 10 cycles into a sweep, then start+abort together, then restart.
    eq_mode = 0;
    pulse_start();
    repeat (9) @(posedge C);
    #1;
    check("t4_key_before_abort", 32'(key_out), 2'b01);
    @(negedge C);
    abort = 1'b1;
    @(posedge C);
    #1;
    abort = 1'b0;
    check("t4_abort_busy",  32'(busy),  0);
    check("t4_abort_done",  32'(done),  0);
    check("t4_abort_found", 32'(found), 0);
    @(negedge C);
    start = 1'b1;
    abort = 1'b1;
    @(posedge C);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("t4_start_abort_busy", 32'(busy), 0);
    pulse_start();
    check("t4_restart_busy", 32'(busy),    1);
    check("t4_restart_key",  32'(key_out), 0);
    check("t4_restart_pat",  32'(pat_out), 0);
    wait_done(200, cyc);
    check("t4_cycles", 32'(cyc), 72);

    // 5: async reset between edges mid-APPLY, then start pulses while busy.
    pulse_start();
    repeat (2) @(posedge C);
    #3;
    R = 1'b0;
    #1;
    check("t5_rst_busy",    32'(busy),    0);
    check("t5_rst_pat",     32'(pat_out), 0);
    check("t5_rst_key",     32'(key_out), 0);
    check("t5_rst_done",    32'(done),    0);
    check("t5_rst_found",   32'(found),   0);
    @(negedge C);
    R = 1'b1;
    pulse_start();
    cyc = 0;
    while (!done && cyc < 200) begin
      start = (cyc == 5 || cyc == 20 || cyc == 40);
      @(posedge C);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("t5_cycles_no_restart", 32'(cyc),       72);
    check("t5_key_found",         32'(key_found), 2'b01);

    // 6: SETTLE=3, eq_in glitches in the first three hold cycles of each pair.
    @(negedge C);
    start2 = 1'b1;
    @(posedge C);
    #1;
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 400) begin
      case (cyc % 5)
        0:       eq2 = 2'b00;
        1:       eq2 = 2'b10;
        2:       eq2 = 2'b01;
        default: eq2 = 2'b11;
      endcase
      @(posedge C);
      #1;
      cyc++;
    end
    check("t6_cycles",    32'(cyc),        160);
    check("t6_done",      32'(done2),      1);
    check("t6_found",     32'(found2),     1);
    check("t6_key_found", 32'(key_found2), 0);
    check("t6_fail_mask", 32'(fail_mask2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
